aes128_iter_ctrl: RTL and testbench
===================================

# aes128_iter_ctrl

Iterative AES-128 encryption controller. It accepts a 128-bit plaintext and cipher key over a valid/ready handshake, then sequences ten rounds through a single shared round datapath. Round keys are expanded on the fly, one per cycle, and the ciphertext is presented on a valid/ready output. The block sits between the host-side block buffer and the downstream ciphertext sink, and is the only user of the full-round and last-round combinational logic.

## Interface
- NUM_ROUNDS, 10: AES-128 round count; fixed, not meant to be overridden.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  plaintext/key pair present.
- in_ready  output  1  controller can accept a block.
- plaintext  input  128  FIPS-197 byte order, byte 0 in [127:120].
- key  input  128  cipher key, same byte order.
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  sink accepts ciphertext.
- ciphertext  output  128  result, FIPS-197 byte order.
- busy  output  1  high in every state except IDLE.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - ROUND: rounds 1..9, full round with MixColumns.
  - FINAL: round 10, no MixColumns.
  - DONE: out_valid=1.
- Accept happens when in_valid && in_ready at an edge. On that edge:
  - state_reg <= plaintext ^ key (initial AddRoundKey).
  - rk_reg <= key.
  - rnd <= 1.
  - FSM -> ROUND.
- ROUND, each cycle:
  - rk_next = key_step(rk_reg, RCON[rnd-1]).
  - state_reg <= full_round(state_reg, rk_next).
  - rk_reg <= rk_next.
  - rnd <= rnd+1.
  - When rnd==9, go to FINAL.
- FINAL: state_reg <= last_round(state_reg, key_step(rk_reg, 8'h36)). FSM -> DONE.
- DONE: ciphertext = state_reg. On out_valid && out_ready, go to IDLE.
- RCON sequence: 01,02,04,08,10,20,40,80,1b,36.
- rnd is a 4-bit counter and never exceeds 10.
- Any row/column transposition the round datapaths need is internal. The port byte order is always FIPS-197.
- Inputs are sampled only at the accept edge. Later changes to plaintext/key have no effect.

## Timing
- Reset values: in_ready=0 while rst is high and 1 in the cycle after release (FSM=IDLE). out_valid=0, busy=0, ciphertext=0. state_reg, rk_reg and rnd are cleared.
- Latency: out_valid rises 10 edges after the accept edge (9 ROUND edges + 1 FINAL edge).
- Throughput: 12 cycles per block minimum (accept cycle, 10 compute cycles, 1 handshake cycle when out_ready=1).
- in_ready is low from the accept edge until the FSM has returned to IDLE. There is no accept in the same cycle as the output handshake.
- Backpressure: while in DONE with out_ready=0, ciphertext and out_valid stay stable indefinitely.
- in_valid while busy is ignored. The source must hold it until in_ready.
- Reset mid-operation (any state) aborts the block:
  - Outputs take their reset values on the next edge.
  - No partial ciphertext is ever flagged valid.
- rst has priority over the handshakes in the same cycle.
- ciphertext is driven directly from state_reg, with no combinational path from inputs to outputs.
- out_valid is asserted only in DONE.

## Structure
- Shared package aes_pkg holds:
  - the FSM state encoding (IDLE, ROUND, FINAL, DONE);
  - the RCON table;
  - NUM_ROUNDS;
  - the byte-transpose function used by the round datapaths.
- Sub-module aes_key_step: combinational single-round key expansion (RotWord, SubWord, RCON XOR, word chain), with ports rk_in, rcon, rk_out.
- The controller instantiates:
  - aes_key_step once;
  - the existing combinational full-round datapath once;
  - the existing last-round datapath once.
- The full-round and last-round outputs are muxed into state_reg by FSM state.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a. out_valid rises exactly 10 edges after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32. Check the round-1 internal state is a0fafe17 88542cb1 23a33939 2a6c7605 ^ shifted state.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> ciphertext unchanged, in_ready=0, busy=1. Raise out_ready -> IDLE on the next edge.
- Back-to-back: keep in_valid high with two C.1/App. B blocks -> both results correct and in order, with a minimum 12-cycle spacing between accepts.
- Reset at the 5th ROUND cycle -> out_valid never asserts for that block. in_ready=1 one cycle after rst drops. A fresh C.1 block completes correctly.
- Input perturbation: change plaintext/key every cycle after the accept edge -> the result still matches the values sampled at accept.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM encoding, round constants,
// S-box and the byte-level round transforms used by the datapaths.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } aes_state_e;

    localparam logic [127:0] SBOX_ROW [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [127:0] row;
        row = SBOX_ROW[b[7:4]];
        return row[{~b[3:0], 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column-major (FIPS byte order) <-> row-major; self-inverse.
    function automatic logic [127:0] transpose(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                t[127-8*(4*r+c) -: 8] = s[127-8*(4*c+r) -: 8];
            end
        end
        return t;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] t;
        logic [31:0]  w;
        t = transpose(s);
        for (int r = 0; r < 4; r++) begin
            w = t[127-32*r -: 32];
            t[127-32*r -: 32] = (w << (8*r)) | (w >> (32-8*r));
        end
        return transpose(t);
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_full_round.sv
// Rounds 1..9: SubBytes, ShiftRows, MixColumns, AddRoundKey.
module aes_full_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rk,
    output logic [127:0] state_out
);

    assign state_out = mix_columns(shift_rows(sub_bytes(state_in))) ^ rk;

endmodule

// File: rtl/aes_key_step.sv
// One step of AES-128 key expansion: next round key from the
// current one and the round constant.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk_in,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, temp;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = rk_in[127:96];
    assign w1 = rk_in[95:64];
    assign w2 = rk_in[63:32];
    assign w3 = rk_in[31:0];

    assign rot  = {w3[23:0], w3[31:24]};
    assign temp = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]),
                   sbox(rot[15:8]), sbox(rot[7:0])};

    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign rk_out = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_last_round.sv
// Round 10: SubBytes, ShiftRows, AddRoundKey (no MixColumns).
module aes_last_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rk,
    output logic [127:0] state_out
);

    assign state_out = shift_rows(sub_bytes(state_in)) ^ rk;

endmodule

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryption: one round per cycle through a shared
// round datapath, round keys expanded on the fly.
module aes128_iter_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);

    localparam logic [3:0] LAST_FULL = 4'(NUM_ROUNDS - 1);

    aes_state_e   st_q, st_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         rdy_q, rdy_d;
    logic [7:0]   rcon_cur;
    logic [127:0] rk_next, full_out, last_out;

    // rnd reaches 10 in FINAL, selecting the last constant (8'h36).
    assign rcon_cur = rcon_of(rnd_q - 4'd1);

    aes_key_step u_key_step (
        .rk_in  (rk_q),
        .rcon   (rcon_cur),
        .rk_out (rk_next)
    );

    aes_full_round u_full_round (
        .state_in  (state_q),
        .rk        (rk_next),
        .state_out (full_out)
    );

    aes_last_round u_last_round (
        .state_in  (state_q),
        .rk        (rk_next),
        .state_out (last_out)
    );

    assign in_ready   = rdy_q;
    assign out_valid  = (st_q == DONE);
    assign busy       = (st_q != IDLE);
    assign ciphertext = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= IDLE;
            state_q <= '0;
            rk_q    <= '0;
            rnd_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        state_d = state_q;
        rk_d    = rk_q;
        rnd_d   = rnd_q;
        unique case (st_q)
            IDLE: begin
                if (in_valid && rdy_q) begin
                    state_d = plaintext ^ key;
                    rk_d    = key;
                    rnd_d   = 4'd1;
                    st_d    = ROUND;
                end
            end
            ROUND: begin
                state_d = full_out;
                rk_d    = rk_next;
                rnd_d   = rnd_q + 4'd1;
                if (rnd_q == LAST_FULL) begin
                    st_d = FINAL;
                end
            end
            FINAL: begin
                state_d = last_out;
                rk_d    = rk_next;
                st_d    = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    rnd_d = 4'd0;
                    st_d  = IDLE;
                end
            end
        endcase
        // Registered so in_ready stays low throughout reset.
        rdy_d = (st_d == IDLE);
    end

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Self-checking bench for aes128_iter_ctrl against a byte-array
// AES-128 reference model and the FIPS-197 known-answer vectors.
module tb_aes128_iter_ctrl;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;

    int vectors;
    int miscompares;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;

    aes128_iter_ctrl u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    logic [7:0] sb_tab [256];

    function automatic logic [7:0] gf_dbl(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = gf_dbl(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ 8'h63;
            for (int n = 1; n < 5; n++) begin
                s = s ^ ((inv << n) | (inv >> (8 - n)));
            end
            sb_tab[x] = s;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb_tab[tmp[23:16]], sb_tab[tmp[15:8]],
                       sb_tab[tmp[7:0]], sb_tab[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gf_dbl(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = p[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sb_tab[s[r][(c+r)%4]];
            s = t;
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[0][c]; a1 = t[1][c]; a2 = t[2][c]; a3 = t[3][c];
                    s[0][c] = gf_mul(a0, 2) ^ gf_mul(a1, 3) ^ a2 ^ a3;
                    s[1][c] = a0 ^ gf_mul(a1, 2) ^ gf_mul(a2, 3) ^ a3;
                    s[2][c] = a0 ^ a1 ^ gf_mul(a2, 2) ^ gf_mul(a3, 3);
                    s[3][c] = gf_mul(a0, 3) ^ a1 ^ a2 ^ gf_mul(a3, 2);
                end
            end
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
        end
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(4*c+r) -: 8] = s[r][c];
        return o;
    endfunction

    // ---------------- helpers ----------------
    logic [127:0] src_k [$];
    logic [127:0] src_p [$];
    logic [127:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_accept(input logic [127:0] k, input logic [127:0] p);
        int n;
        in_valid  = 1'b1;
        key       = k;
        plaintext = p;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL accept_timeout: in_ready=%b want 1", in_ready);
            miscompares++;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int edges);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    task automatic run_stream(input int rdy_pct, input bit perturb);
        int cyc, last_acc, idx, got, n;
        bit acc, hs;
        cyc = 0; last_acc = -1; idx = 0; got = 0;
        n = src_k.size();
        while (got < n && cyc < 40 * n + 50) begin
            if (perturb && busy) begin
                in_valid  = 1'($urandom_range(1));
                key       = {$urandom, $urandom, $urandom, $urandom};
                plaintext = {$urandom, $urandom, $urandom, $urandom};
            end else if (idx < n) begin
                in_valid  = 1'b1;
                key       = src_k[idx];
                plaintext = src_p[idx];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(99) < rdy_pct);
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            vectors++;
            if (in_ready === 1'b1 && out_valid === 1'b1) begin
                $display("FAIL ready_and_valid: in_ready=%b out_valid=%b want not both", in_ready, out_valid);
                miscompares++;
            end
            if (hs) begin
                vectors++;
                if (ciphertext !== exp_q[got]) begin
                    $display("FAIL stream_ct[%0d]: got %h want %h", got, ciphertext, exp_q[got]);
                    miscompares++;
                end
                got++;
            end
            if (acc) begin
                if (last_acc >= 0) begin
                    vectors++;
                    if (cyc - last_acc < 12) begin
                        $display("FAIL accept_spacing: got %0d want >=12", cyc - last_acc);
                        miscompares++;
                    end
                end
                last_acc = cyc;
                idx++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (got != n) begin
            $display("FAIL stream_timeout: got %0d results want %0d", got, n);
            miscompares++;
        end
        src_k.delete();
        src_p.delete();
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        key = '0;
        plaintext = '0;
        tick();
        tick();
        vectors += 4;
        if (in_ready !== 1'b0) begin
            $display("FAIL rst_in_ready: got %b want 0", in_ready); miscompares++;
        end
        if (out_valid !== 1'b0) begin
            $display("FAIL rst_out_valid: got %b want 0", out_valid); miscompares++;
        end
        if (busy !== 1'b0) begin
            $display("FAIL rst_busy: got %b want 0", busy); miscompares++;
        end
        if (ciphertext !== 128'h0) begin
            $display("FAIL rst_ct: got %h want 0", ciphertext); miscompares++;
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL rst_release_ready: got %b want 1", in_ready); miscompares++;
        end
    endtask

    task automatic test_fips_c1();
        int e;
        do_accept(C1_KEY, C1_PT);
        wait_out(e);
        vectors += 2;
        if (e != 10) begin
            $display("FAIL c1_latency: got %0d edges want 10", e); miscompares++;
        end
        if (ciphertext !== C1_CT) begin
            $display("FAIL c1_ct: got %h want %h", ciphertext, C1_CT); miscompares++;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors += 2;
        if (out_valid !== 1'b0) begin
            $display("FAIL c1_handshake_valid: got %b want 0", out_valid); miscompares++;
        end
        if (in_ready !== 1'b1) begin
            $display("FAIL c1_handshake_ready: got %b want 1", in_ready); miscompares++;
        end
    endtask

    task automatic test_fips_b();
        int e;
        do_accept(B_KEY, B_PT);
        tick();
        vectors += 2;
        if (u_dut.state_q !== B_R1) begin
            $display("FAIL b_round1_state: got %h want %h", u_dut.state_q, B_R1); miscompares++;
        end
        if (u_dut.rk_q !== B_RK1) begin
            $display("FAIL b_round1_key: got %h want %h", u_dut.rk_q, B_RK1); miscompares++;
        end
        wait_out(e);
        vectors += 2;
        if (e != 9) begin
            $display("FAIL b_latency: got %0d remaining edges want 9", e); miscompares++;
        end
        if (ciphertext !== B_CT) begin
            $display("FAIL b_ct: got %h want %h", ciphertext, B_CT); miscompares++;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int e;
        int bad;
        do_accept(C1_KEY, C1_PT);
        wait_out(e);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ciphertext !== C1_CT || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
                bad++;
            end
        end
        vectors++;
        if (bad != 0) begin
            $display("FAIL bp_hold: got %0d unstable cycles want 0 (ct %h)", bad, ciphertext);
            miscompares++;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors += 2;
        if (busy !== 1'b0) begin
            $display("FAIL bp_release_busy: got %b want 0", busy); miscompares++;
        end
        if (out_valid !== 1'b0) begin
            $display("FAIL bp_release_valid: got %b want 0", out_valid); miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        src_k.push_back(C1_KEY); src_p.push_back(C1_PT); exp_q.push_back(C1_CT);
        src_k.push_back(B_KEY);  src_p.push_back(B_PT);  exp_q.push_back(B_CT);
        run_stream(100, 1'b0);
    endtask

    task automatic test_reset_mid();
        int e;
        int seen;
        do_accept(C1_KEY, C1_PT);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        vectors += 3;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL mid_rst_flags: got valid=%b busy=%b want 0 0", out_valid, busy); miscompares++;
        end
        if (ciphertext !== 128'h0) begin
            $display("FAIL mid_rst_ct: got %h want 0", ciphertext); miscompares++;
        end
        if (in_ready !== 1'b0) begin
            $display("FAIL mid_rst_ready: got %b want 0", in_ready); miscompares++;
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL mid_rst_release: got %b want 1", in_ready); miscompares++;
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid === 1'b1) seen++;
            tick();
        end
        vectors++;
        if (seen != 0) begin
            $display("FAIL mid_rst_no_valid: got %0d valid cycles want 0", seen); miscompares++;
        end
        do_accept(C1_KEY, C1_PT);
        wait_out(e);
        vectors++;
        if (ciphertext !== C1_CT || out_valid !== 1'b1) begin
            $display("FAIL mid_rst_fresh: got %h want %h", ciphertext, C1_CT); miscompares++;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [127:0] k, p;
        for (int i = 0; i < 16; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            src_k.push_back(k); src_p.push_back(p); exp_q.push_back(aes_ref(k, p));
        end
        run_stream(60, 1'b0);
    endtask

    task automatic test_perturb();
        logic [127:0] k, p;
        for (int i = 0; i < 4; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            src_k.push_back(k); src_p.push_back(p); exp_q.push_back(aes_ref(k, p));
        end
        run_stream(100, 1'b1);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        key = '0;
        plaintext = '0;
        build_sbox();
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_perturb();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
